// File: rtl/irq_scheduler_if.sv
// CPU-side bus and interrupt handshake between the CPU and irq_scheduler.
// master = CPU/bus side, slave = the scheduler peripheral.
interface irq_scheduler_if;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        int_o;
    logic        intack;
    logic [2:0]  intv;

    modport master (
        output sel, addr, we, wdata, intack,
        input  rdata, int_o, intv
    );

    modport slave (
        input  sel, addr, we, wdata, intack,
        output rdata, int_o, intv
    );
endinterface

// File: rtl/irq_scheduler.sv
// Sequential priority interrupt scheduler: synchronised edge capture, masking,
// fixed-priority nesting (IRQ0 highest), INT/INTACK handshake, 4-word register file.
module irq_scheduler #(
    parameter int NUM_IRQ     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    irq_scheduler_if.slave     bus_if
);

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_INSERV  = 2'd2;
    localparam logic [1:0] REG_EOI     = 2'd3;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d;
    logic               int_q, int_d;
    logic [2:0]         intv_q, intv_d;

    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] cand_oh;
    logic [NUM_IRQ-1:0] w1c_bits;
    logic [3:0]         cand_idx;
    logic [3:0]         ceil_idx;
    logic               cand_vld;
    logic               ack;
    logic               wr_pend, wr_mask, wr_eoi;
    logic               unused_wdata;

    // Index of the lowest set bit; NUM_IRQ when the vector is empty.
    function automatic logic [3:0] lowest_idx(input logic [NUM_IRQ-1:0] v);
        logic [3:0] idx;
        idx = 4'(NUM_IRQ);
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [NUM_IRQ-1:0] lowest_oh(input logic [NUM_IRQ-1:0] v);
        return v & (~v + NUM_IRQ'(1));
    endfunction

    // Input synchroniser chain followed by the previous-value flop for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign eligible = pending_q & ~mask_q;
    assign cand_vld = |eligible;
    assign cand_idx = lowest_idx(eligible);
    assign cand_oh  = lowest_oh(eligible);
    assign ceil_idx = lowest_idx(isr_q);

    // An acknowledge with nothing left to grant (e.g. just cleared) is dropped.
    assign ack = bus_if.intack & int_q & cand_vld;

    assign wr_pend  = bus_if.sel & bus_if.we & (bus_if.addr == REG_PENDING);
    assign wr_mask  = bus_if.sel & bus_if.we & (bus_if.addr == REG_MASK);
    assign wr_eoi   = bus_if.sel & bus_if.we & (bus_if.addr == REG_EOI);
    assign w1c_bits = wr_pend ? bus_if.wdata[NUM_IRQ-1:0] : '0;

    assign unused_wdata = &{1'b0, bus_if.wdata[15:NUM_IRQ]};

    always_comb begin
        // Fresh edges are OR-ed last so neither W1C nor acknowledge can swallow them.
        pending_d = (pending_q & ~w1c_bits & ~(ack ? cand_oh : '0)) | rise;
        mask_d    = wr_mask ? bus_if.wdata[NUM_IRQ-1:0] : mask_q;
        // EOI clears before the acknowledge sets, so both land in one cycle.
        isr_d     = (isr_q & ~(wr_eoi ? lowest_oh(isr_q) : '0)) | (ack ? cand_oh : '0);
        int_d     = !ack && cand_vld && (cand_idx < ceil_idx);
        intv_d    = ack ? cand_idx[2:0] : intv_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            mask_q    <= '1;
            isr_q     <= '0;
            int_q     <= 1'b0;
            intv_q    <= 3'd0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            isr_q     <= isr_d;
            int_q     <= int_d;
            intv_q    <= intv_d;
        end
    end

    always_comb begin
        bus_if.rdata = 16'd0;
        if (bus_if.sel) begin
            case (bus_if.addr)
                REG_PENDING: bus_if.rdata = 16'(pending_q);
                REG_MASK:    bus_if.rdata = 16'(mask_q);
                REG_INSERV:  bus_if.rdata = 16'(isr_q);
                default:     bus_if.rdata = {13'd0, intv_q};
            endcase
        end
    end

    assign bus_if.int_o = int_q;
    assign bus_if.intv  = intv_q;

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed bench for irq_scheduler: edge capture, nesting, masking, W1C, EOI, reset.
module tb_irq_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq;
    int         n_total;
    int         n_bad;
    logic [15:0] rd;

    irq_scheduler_if bus ();

    irq_scheduler #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .irq_i  (irq),
        .bus_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%04h expected=0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [15:0] d);
        bus.sel  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = a;
        #1;
        d = bus.rdata;
        bus.sel = 1'b0;
    endtask

    task automatic wrreg(input logic [1:0] a, input logic [15:0] d);
        bus.sel   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.sel = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic ack();
        bus.intack = 1'b1;
        tick();
        bus.intack = 1'b0;
    endtask

    task automatic pulse(input int i);
        irq[i] = 1'b1;
        tick();
        irq[i] = 1'b0;
    endtask

    task automatic chkreg(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] v;
        rdreg(a, v);
        chk(tag, v, exp);
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
        irq        = '0;
        rst_n      = 1'b0;
        bus.sel    = 1'b0;
        bus.we     = 1'b0;
        bus.addr   = 2'd0;
        bus.wdata  = 16'd0;
        bus.intack = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();

        // reset state
        chkreg("rst_pending", 2'd0, 16'h0000);
        chkreg("rst_mask",    2'd1, 16'h00FF);
        chkreg("rst_inserv",  2'd2, 16'h0000);
        chkreg("rst_eoi_rd",  2'd3, 16'h0000);
        chk("rst_int", 16'(bus.int_o), 16'h0000);
        bus.sel = 1'b0;
        bus.addr = 2'd1;
        #1;
        chk("rdata_unsel", bus.rdata, 16'h0000);

        // single IRQ3 pulse
        wrreg(2'd1, 16'h0000);
        pulse(3);
        tick(1);
        chk("irq3_int_early", 16'(bus.int_o), 16'h0000);
        tick(1);
        chkreg("irq3_pending", 2'd0, 16'h0008);
        chk("irq3_int_same", 16'(bus.int_o), 16'h0000);
        tick();
        chk("irq3_int", 16'(bus.int_o), 16'h0001);
        ack();
        chk("irq3_intv", 16'(bus.intv), 16'h0003);
        chkreg("irq3_inserv", 2'd2, 16'h0008);
        chkreg("irq3_pend_clr", 2'd0, 16'h0000);
        chk("irq3_int_low", 16'(bus.int_o), 16'h0000);

        // nesting: IRQ5 blocked by IRQ3, IRQ1 preempts
        pulse(5);
        tick(3);
        chkreg("irq5_pending", 2'd0, 16'h0020);
        chk("irq5_blocked", 16'(bus.int_o), 16'h0000);
        pulse(1);
        tick(3);
        chk("irq1_int", 16'(bus.int_o), 16'h0001);
        ack();
        chk("irq1_intv", 16'(bus.intv), 16'h0001);
        chkreg("irq1_inserv", 2'd2, 16'h000A);
        chk("irq1_int_low", 16'(bus.int_o), 16'h0000);
        wrreg(2'd3, 16'h1234);
        chkreg("eoi1_inserv", 2'd2, 16'h0008);
        chkreg("eoi1_rd_intv", 2'd3, 16'h0001);
        tick();
        chk("eoi1_int", 16'(bus.int_o), 16'h0000);
        wrreg(2'd3, 16'h0000);
        chkreg("eoi2_inserv", 2'd2, 16'h0000);
        tick();
        chk("irq5_int", 16'(bus.int_o), 16'h0001);
        ack();
        chk("irq5_intv", 16'(bus.intv), 16'h0005);
        chkreg("irq5_inserv", 2'd2, 16'h0020);
        wrreg(2'd3, 16'h0000);
        wrreg(2'd3, 16'h0000);
        chkreg("eoi_empty", 2'd2, 16'h0000);

        // masking and W1C
        wrreg(2'd1, 16'h00FF);
        pulse(0);
        tick(2);
        chkreg("irq0_pending", 2'd0, 16'h0001);
        tick(2);
        chk("irq0_masked", 16'(bus.int_o), 16'h0000);
        wrreg(2'd1, 16'hFFFE);
        chkreg("mask_rd", 2'd1, 16'h00FE);
        tick();
        chk("irq0_unmasked", 16'(bus.int_o), 16'h0001);
        wrreg(2'd0, 16'h0001);
        chkreg("w1c_pending", 2'd0, 16'h0000);
        tick();
        chk("w1c_int_drop", 16'(bus.int_o), 16'h0000);
        wrreg(2'd2, 16'h00FF);
        chkreg("inserv_ro", 2'd2, 16'h0000);

        // simultaneous IRQ2 and IRQ6, IRQ2 held high
        wrreg(2'd1, 16'h0000);
        irq = 8'h44;
        tick();
        irq[6] = 1'b0;
        tick(2);
        chkreg("dual_pending", 2'd0, 16'h0044);
        tick();
        chk("dual_int", 16'(bus.int_o), 16'h0001);
        ack();
        chk("dual_intv2", 16'(bus.intv), 16'h0002);
        tick(4);
        chkreg("held_no_retrig", 2'd0, 16'h0040);
        wrreg(2'd3, 16'h0000);
        tick();
        chk("dual_int6", 16'(bus.int_o), 16'h0001);
        ack();
        chk("dual_intv6", 16'(bus.intv), 16'h0006);
        wrreg(2'd3, 16'h0000);
        irq[2] = 1'b0;
        tick(4);
        chkreg("dual_clean", 2'd0, 16'h0000);

        // IRQ4 re-edge coinciding with its acknowledge
        pulse(4);
        tick(3);
        chk("irq4_int", 16'(bus.int_o), 16'h0001);
        irq[4] = 1'b1;
        tick();
        irq[4] = 1'b0;
        tick();
        ack();
        chk("irq4_intv", 16'(bus.intv), 16'h0004);
        chkreg("irq4_requeued", 2'd0, 16'h0010);
        chkreg("irq4_inserv", 2'd2, 16'h0010);
        chk("irq4_int_low", 16'(bus.int_o), 16'h0000);
        ack();
        chkreg("stray_ack_pend", 2'd0, 16'h0010);
        chkreg("stray_ack_isr", 2'd2, 16'h0010);
        chk("stray_ack_intv", 16'(bus.intv), 16'h0004);

        // reset between int_o rising and intack
        wrreg(2'd3, 16'h0000);
        tick();
        chk("pre_rst_int", 16'(bus.int_o), 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        chkreg("mid_rst_pending", 2'd0, 16'h0000);
        chkreg("mid_rst_mask",    2'd1, 16'h00FF);
        chkreg("mid_rst_inserv",  2'd2, 16'h0000);
        chk("mid_rst_int", 16'(bus.int_o), 16'h0000);
        tick();
        rst_n = 1'b1;
        ack();
        chk("post_rst_intv", 16'(bus.intv), 16'h0000);
        chk("post_rst_int", 16'(bus.int_o), 16'h0000);
        chkreg("post_rst_isr", 2'd2, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_scheduler.md
Name: irq_scheduler

Overview:
- Sequential replacement for the combinational priority interrupt controller.
- Synchronises and edge-detects up to 8 interrupt request lines and latches them as pending.
- Applies a software mask, arbitrates by fixed priority (IRQ0 highest) with nesting, and runs the INT/INTACK handshake with the CPU.
- Sits on the CPU data bus as a 4-word memory-mapped peripheral; the system decodes word addresses 0x7FC–0x7FF onto sel/addr.

Parameters:
- NUM_IRQ, 8: number of request lines, 1..8; vector width stays 3.
- SYNC_STAGES, 2: flip-flop stages on each irq input before edge detection, minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq  in  NUM_IRQ  asynchronous request lines, active high, rising-edge triggered.
- sel  in  1  register select, high when the address decodes to 0x7FC–0x7FF.
- addr  in  2  register index.
- we  in  1  write strobe (MEMLD), qualified by sel.
- wdata  in  16  CPU write data.
- rdata  out  16  register read data, combinational from addr; zero when sel is low.
- int_o  out  1  interrupt request to the CPU.
- intack  in  1  CPU acknowledge, one-cycle pulse.
- intv  out  3  vector of the acknowledged source, zero-extended onto the data bus by the top level.

Behaviour:
- Reset (async assert, sync release): pending = 0, mask = all 1 (all masked), in_service = 0, sync/edge flops = 0, int_o = 0, intv = 0.
- Input path:
  - irq passes through SYNC_STAGES flops, then a previous-value flop.
  - A rise sets pending[i] on the following edge, so pending is set 3 cycles after the pin rises when SYNC_STAGES = 2.
  - A level held high does not retrigger; it must fall and rise again.
- Candidate = lowest index i with pending[i] & ~mask[i].
- Ceiling = lowest index set in in_service (NUM_IRQ when none is set).
- int_o is registered: next int_o = candidate exists AND candidate index < ceiling. Nesting is therefore allowed only for strictly higher priority.
- Acknowledge (intack high at a clock edge with int_o high):
  - pending[cand] cleared, in_service[cand] set.
  - intv ← cand, registered and held until the next acknowledge.
  - int_o low in the following cycle.
  - The candidate is the one evaluated combinationally in the acknowledge cycle; it may differ from the source that raised int_o. The higher one wins.
- intack while int_o is low: ignored; no state change; intv unchanged.
- Register map (addr):
  - 0 PENDING: read pending; write-1-to-clear.
  - 1 MASK: read/write, bits [NUM_IRQ-1:0]; 1 = masked.
  - 2 IN_SERVICE: read-only; writes ignored.
  - 3 EOI: write (any data) clears the lowest-index in_service bit; no effect if in_service = 0; reads return {13'b0, intv}.
- Unused upper bits read 0.
- Simultaneous events:
  - A new edge on bit i in the same cycle as a W1C of bit i: set wins, the edge is not lost.
  - A new edge on bit i in the same cycle as acknowledge of bit i: pending[i] stays set (second request queued).
  - EOI and acknowledge in the same cycle: the EOI clear is applied first, then the acknowledge set.
- Masking a source after int_o rose: int_o drops the next cycle if no other eligible candidate remains. Pending is retained.
- Reset mid-handshake: all state cleared immediately; a later intack is ignored.

Test Plan:
- Reset, then mask = 0x00; pulse irq[3] for 1 cycle → PENDING = 0x08 after 3 cycles; int_o high on the next cycle; intack → intv = 3, IN_SERVICE = 0x08, PENDING = 0, int_o low.
- With IRQ3 in service, raise irq[5] → int_o stays low. Raise irq[1] → int_o high; acknowledge gives intv = 1 and IN_SERVICE = 0x0A. EOI → 0x08; EOI → 0x00; int_o rises for IRQ5 and acknowledge gives intv = 5.
- Mask = 0xFF, pulse irq[0] → PENDING = 0x01, int_o stays 0. Write mask 0xFE → int_o = 1 two cycles later. Write PENDING = 0x01 before intack → int_o falls.
- irq[2] and irq[6] rise in the same cycle → acknowledges return intv = 2, then (after EOI) intv = 6. Holding irq[2] high produces no second pending.
- irq[4] edge coincides with the intack of IRQ4 → PENDING bit 4 remains 1 after the acknowledge. intack pulsed with int_o = 0 → no register change.
- Assert rst_n = 0 between int_o rising and intack → all registers at reset values; mask reads 0x00FF; intack afterwards gives intv = 0 and int_o = 0.
